fifo_arbiter: RTL and testbench

Downstream consumer of the four input-queue FIFOs. Each cycle it selects one non-empty input FIFO and pops its head word. It routes the word to one of four output FIFOs using the word's destination field. It stalls all pops while any output FIFO reports almost_full, and gives backpressure-aware transfer between the input and output FIFO banks.

---
 rtl/fifo_arbiter_pkg.sv | 26 ++
 rtl/fifo_arbiter_arb_grant.sv | 48 ++++
 rtl/fifo_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_arbiter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbiter_pkg.sv
// Shared definitions for the fifo_arbiter slice: FSM state encoding,
// port count, default word width and destination field position.
package fifo_arbiter_pkg;

    localparam int NUM_PORTS      = 4;
    localparam int DATA_WIDTH_DEF = 6;
    localparam int DEST_MSB       = DATA_WIDTH_DEF - 1;
    localparam int DEST_LSB       = DATA_WIDTH_DEF - 2;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2
    } state_t;

    // Encode a one-hot (or zero) port vector into a 2-bit index; zero maps to 0.
    function automatic logic [1:0] onehot_to_idx(input logic [NUM_PORTS-1:0] oh);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (oh[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fifo_arbiter_arb_grant.sv
// Combinational grant selector for fifo_arbiter.
// Macro ARB_ROUND_ROBIN_EN: defined -> round-robin search starting at
// rr_ptr+1 (mod 4); undefined -> fixed priority, port 0 highest.
module fifo_arbiter_arb_grant (
    input  logic [3:0] req,
    input  logic [1:0] rr_ptr,
    output logic [3:0] grant
);
    import fifo_arbiter_pkg::*;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] idx;
    logic       found;

    // Walk the ports starting just after the last granted one; first requester wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end
`else
    logic found;
    logic unused_rr_ptr;

    // The pointer only matters for round-robin; fold it away here.
    assign unused_rr_ptr = ^rr_ptr;

    // Lowest-numbered requesting port wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!found && req[i]) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/fifo_arbiter.sv
// fifo_arbiter: pops one non-empty input FIFO per cycle and routes the word
// to the output FIFO named by its top two bits, one cycle later.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin arbitration
// instead of fixed priority (port 0 highest).
//
// Handshake: pop[i] is a combinational read strobe -- the input FIFO
// advances on the edge where pop[i]=1, and pop is only raised for a port
// whose in_empty bit is low. push[d] is a registered write strobe held for
// exactly one cycle together with data_out; the output FIFO accepts on the
// edge that ends that cycle. out_almost_full is the only backpressure and
// gates pop in the same cycle; a word already in the register still goes out.
module fifo_arbiter #(
    parameter int DATA_WIDTH = fifo_arbiter_pkg::DATA_WIDTH_DEF,
    parameter int NUM_PORTS  = fifo_arbiter_pkg::NUM_PORTS
) (
    input  logic                            clk,
    input  logic                            reset_L,
    input  logic [NUM_PORTS-1:0]            in_empty,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]            out_almost_full,
    input  logic [NUM_PORTS-1:0]            out_full,
    output logic [NUM_PORTS-1:0]            pop,
    output logic [NUM_PORTS-1:0]            push,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            pause,
    output logic                            idle,
    output logic                            error,
    output logic [1:0]                      state_dbg
);
    import fifo_arbiter_pkg::*;

    state_t                  state;
    state_t                  state_next;
    logic [NUM_PORTS-1:0]    req;
    logic [NUM_PORTS-1:0]    grant;
    logic [1:0]              rr_ptr;
    logic [1:0]              grant_idx;
    logic [1:0]              dest;
    logic [NUM_PORTS-1:0]    dest_oh;
    logic [DATA_WIDTH-1:0]   sel_word;
    logic [NUM_PORTS-1:0]    push_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    error_q;

    assign pause     = |out_almost_full;
    assign req       = ~in_empty;
    assign pop       = (state == ST_ACTIVE && !pause) ? grant : '0;
    assign grant_idx = onehot_to_idx(grant);
    assign dest      = sel_word[DATA_WIDTH-1 -: 2];
    assign push      = push_q;
    assign data_out  = data_q;
    assign error     = error_q;
    assign state_dbg = state;

    fifo_arbiter_arb_grant u_arb_grant (
        .req    (req),
        .rr_ptr (rr_ptr),
        .grant  (grant)
    );

    // Mux the granted head word and decode its destination one-hot.
    always_comb begin
        sel_word = '0;
        dest_oh  = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant[i]) sel_word = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        for (int i = 0; i < NUM_PORTS; i++) begin
            dest_oh[i] = (dest == 2'(i));
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Remember the last port popped so the next search starts after it.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            rr_ptr <= 2'd0;
        end else if (|pop) begin
            rr_ptr <= grant_idx;
        end
    end
`else
    logic unused_grant_idx;
    assign rr_ptr           = 2'd0;
    assign unused_grant_idx = ^grant_idx;
`endif

    // Transfer register: a popped word is pushed next cycle unless its target is full.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            push_q  <= '0;
            data_q  <= '0;
            error_q <= 1'b0;
        end else if (|pop) begin
            data_q <= sel_word;
            if (out_full[dest]) begin
                push_q  <= '0;
                error_q <= 1'b1;
            end else begin
                push_q <= dest_oh;
            end
        end else begin
            push_q <= '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and idle decode; ACTIVE holds until inputs are empty and the push register drained.
    always_comb begin
        state_next = state;
        idle       = 1'b0;
        case (state)
            ST_INIT: begin
                state_next = ST_IDLE;
            end
            ST_IDLE: begin
                idle = 1'b1;
                if (in_empty != {NUM_PORTS{1'b1}}) state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                if (in_empty == {NUM_PORTS{1'b1}} && push_q == '0) state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_arbiter.sv
// Testbench for fifo_arbiter: directed scenarios followed by random traffic,
// compared cycle by cycle against a queue-based behavioural model.
module tb_fifo_arbiter;
    import fifo_arbiter_pkg::*;

    localparam int DW = 6;
    localparam int NP = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    logic [NP-1:0]    in_empty;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    out_almost_full;
    logic [NP-1:0]    out_full;
    logic [NP-1:0]    pop;
    logic [NP-1:0]    push;
    logic [DW-1:0]    data_out;
    logic             pause;
    logic             idle;
    logic             error;
    logic [1:0]       state_dbg;

    fifo_arbiter #(.DATA_WIDTH(DW), .NUM_PORTS(NP)) dut (
        .clk             (clk),
        .reset_L         (reset_L),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .out_full        (out_full),
        .pop             (pop),
        .push            (push),
        .data_out        (data_out),
        .pause           (pause),
        .idle            (idle),
        .error           (error),
        .state_dbg       (state_dbg)
    );

    // ---------------- model state / scoreboard ----------------
    logic [DW-1:0] in_q [NP][$];
    logic [DW-1:0] exp_q [$];
    int            checks = 0;
    int            errors = 0;
    state_t        m_state;
    logic [NP-1:0] m_push;
    logic [DW-1:0] m_data;
    logic          m_err;
    int            m_rr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present each queue head as a first-word fall-through FIFO would.
    task automatic drive_inputs();
        for (int i = 0; i < NP; i++) begin
            in_empty[i] = (in_q[i].size() == 0);
            in_data[i*DW +: DW] = in_empty[i] ? DW'($urandom) : in_q[i][0];
        end
    endtask

    function automatic int pick();
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NP; k++) begin
            if (in_q[(m_rr + k) % NP].size() != 0) return (m_rr + k) % NP;
        end
`else
        for (int i = 0; i < NP; i++) begin
            if (in_q[i].size() != 0) return i;
        end
`endif
        return -1;
    endfunction

    task automatic reset_model();
        m_state = ST_INIT;
        m_push  = '0;
        m_data  = '0;
        m_err   = 1'b0;
        m_rr    = 0;
        exp_q.delete();
    endtask

    // Assert reset asynchronously, check outputs clear at once, release after a posedge.
    task automatic do_reset();
        reset_L = 1'b0;
        #1;
        check("rst_push", push, 4'h0);
        check("rst_data", data_out, 6'h00);
        check("rst_error", error, 1'b0);
        check("rst_pop", pop, 4'h0);
        check("rst_idle", idle, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state_dbg, ST_INIT);
        reset_model();
        reset_L = 1'b1;
        drive_inputs();
    endtask

    // One clock: check combinational outputs at negedge, advance the model, check registers after posedge.
    task automatic step();
        int            g;
        logic          pause_m;
        logic [NP-1:0] exp_pop;
        logic [NP-1:0] old_push;
        logic          all_empty;
        logic [DW-1:0] w;
        logic [1:0]    d;
        pause_m = |out_almost_full;
        g = -1;
        if (m_state == ST_ACTIVE && !pause_m) g = pick();
        exp_pop = (g >= 0) ? 4'(1 << g) : 4'h0;
        all_empty = 1'b1;
        for (int i = 0; i < NP; i++) if (in_q[i].size() != 0) all_empty = 1'b0;

        @(negedge clk);
        check("pause", pause, pause_m);
        check("pop", pop, exp_pop);
        check("idle", idle, m_state == ST_IDLE);
        check("state", state_dbg, m_state);

        old_push = m_push;
        if (g >= 0) begin
            w      = in_q[g].pop_front();
            m_data = w;
            d      = w[DW-1 -: 2];
            m_rr   = g;
            if (out_full[d]) begin
                m_push = '0;
                m_err  = 1'b1;
            end else begin
                m_push = 4'(1 << d);
                exp_q.push_back(w);
            end
        end else begin
            m_push = '0;
        end
        case (m_state)
            ST_INIT:   m_state = ST_IDLE;
            ST_IDLE:   if (!all_empty) m_state = ST_ACTIVE;
            ST_ACTIVE: if (all_empty && old_push == '0) m_state = ST_IDLE;
            default:   m_state = ST_INIT;
        endcase

        @(posedge clk);
        #1;
        check("push", push, m_push);
        check("data_out", data_out, m_data);
        check("error", error, m_err);
        if (push !== 4'h0) begin
            if (exp_q.size() == 0) check("sb_extra", push, 4'h0);
            else check("sb_word", data_out, exp_q.pop_front());
        end
        drive_inputs();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        reset_L         = 1'b0;
        out_almost_full = '0;
        out_full        = '0;
        in_empty        = '1;
        in_data         = '0;
        reset_model();
        @(posedge clk);
        #1;

        // Reset release with all inputs empty: INIT one cycle, then IDLE.
        do_reset();
        repeat (4) step();

        // Input 2 with two words routed to outputs 1 and 3.
        in_q[2].push_back(6'b01_0101);
        in_q[2].push_back(6'b11_0011);
        drive_inputs();
        repeat (6) step();

        // Inputs 0 and 3 competing.
        for (int i = 0; i < 3; i++) begin
            in_q[0].push_back(6'(i));
            in_q[3].push_back(6'(6'h30 + i));
        end
        drive_inputs();
        repeat (10) step();

        // almost_full on output 1 mid-stream.
        for (int i = 0; i < 6; i++) in_q[1].push_back(6'(6'h10 + i));
        drive_inputs();
        repeat (3) step();
        out_almost_full = 4'b0010;
        repeat (3) step();
        out_almost_full = 4'b0000;
        repeat (7) step();

        // Overflow on output 0, then more traffic to show error is sticky.
        in_q[0].push_back(6'b00_1010);
        drive_inputs();
        step();
        out_full = 4'b0001;
        repeat (2) step();
        out_full = 4'b0000;
        in_q[3].push_back(6'b10_0111);
        in_q[0].push_back(6'b00_0001);
        drive_inputs();
        repeat (6) step();

        // Reset pulse while a push is pending.
        for (int i = 0; i < 4; i++) in_q[2].push_back(6'(6'h2c + i));
        drive_inputs();
        for (int n = 0; n < 10 && m_push == '0; n++) step();
        do_reset();
        repeat (8) step();

        // Random traffic with occasional pause and overflow.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                int p;
                p = $urandom_range(0, NP - 1);
                if (in_q[p].size() < 8) in_q[p].push_back(DW'($urandom_range(0, 63)));
            end
            out_almost_full = ($urandom_range(0, 7) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0;
            out_full        = ($urandom_range(0, 31) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            drive_inputs();
            step();
        end
        out_almost_full = '0;
        out_full        = '0;
        drive_inputs();
        repeat (40) step();
        check("sb_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
